// File: rtl/trace_pkg.sv
// Shared definitions for the trace buffering path: word layout and marker decoding.
package trace_pkg;

   // Default raw sample width; the marker flag sits directly above the sample.
   localparam int unsigned TRACE_SAMPLE_W = 16;

   // Widest drop-count value the helper below can extract.
   localparam int unsigned DROP_W = 64;

   // Tagged trace word at the default width: flag bit plus payload.
   typedef struct packed {
      logic                      marker;
      logic [TRACE_SAMPLE_W-1:0] payload;
   } trace_word_t;

   // Bit position of the marker flag for a given sample width.
   function automatic int unsigned marker_bit_pos(input int unsigned sample_w);
      return sample_w;
   endfunction

   // Drop count carried by a marker word: the low cnt_w bits, zero-extended.
   function automatic logic [DROP_W-1:0] drop_count(input logic [DROP_W-1:0] word,
                                                    input int unsigned       cnt_w);
      logic [DROP_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < DROP_W; i++) begin
         if (i < cnt_w) r[i] = word[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/trace_fifo_sat_counter.sv
// Saturating accumulator with synchronous reset and clear; never wraps.
module sat_counter
   import trace_pkg::*;
#(
   parameter int unsigned width_p     = 32,
   parameter int unsigned inc_width_p = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   inc_en,
   input  logic [inc_width_p-1:0] inc_val,
   output logic [width_p-1:0]     count
);

   localparam int unsigned sum_w_lp = ((width_p > inc_width_p) ? width_p : inc_width_p) + 1;

   logic [width_p-1:0]  cnt_max;
   logic [sum_w_lp-1:0] sum;
   logic                sat;

   // Full-width sum so an increment wider than the counter still saturates cleanly.
   always_comb begin
      cnt_max = '1;
      sum     = sum_w_lp'(count) + sum_w_lp'(inc_val);
      sat     = (sum > sum_w_lp'(cnt_max));
   end

   // Clear wins over a coincident increment; otherwise add and clamp at all-ones.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc_en) begin
         count <= sat ? cnt_max : sum[width_p-1:0];
      end
   end

endmodule

// File: rtl/trace_fifo.sv
// Show-ahead circular trace buffer with saturating marker/loss statistics.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int unsigned sample_width_p  = TRACE_SAMPLE_W,
   parameter int unsigned counter_width_p = 16,
   parameter int unsigned addr_width_p    = 4,
   parameter int unsigned stat_width_p    = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [sample_width_p:0]   in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [sample_width_p:0]   out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [addr_width_p:0]     occupancy,
   output logic [stat_width_p-1:0]   marker_cnt,
   output logic [stat_width_p-1:0]   lost_total,
   input  logic                      clear_stats
);

   localparam int unsigned           depth_lp  = 1 << addr_width_p;
   localparam int unsigned           flag_lp   = marker_bit_pos(sample_width_p);
   localparam logic [addr_width_p:0] full_lp   = {1'b1, {addr_width_p{1'b0}}};

   logic [sample_width_p:0]   mem [depth_lp];
   logic [addr_width_p-1:0]   wr_ptr;
   logic [addr_width_p-1:0]   rd_ptr;
   logic                      push;
   logic                      pop;
   logic                      marker_push;
   logic [DROP_W-1:0]         drop;

   // Handshake decode; full/empty come from occupancy so in_ready never sees out_ready.
   always_comb begin
      in_ready    = (occupancy != full_lp);
      out_valid   = (occupancy != '0);
      out_data    = mem[rd_ptr];
      push        = in_valid && in_ready;
      pop         = out_valid && out_ready;
      marker_push = push && in_data[flag_lp];
      drop        = drop_count(DROP_W'(in_data), counter_width_p);
   end

   // Storage write; contents are intentionally left unreset.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally at the depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   sat_counter #(
      .width_p     (stat_width_p),
      .inc_width_p (1)
   ) u_marker_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (clear_stats),
      .inc_en  (marker_push),
      .inc_val (1'b1),
      .count   (marker_cnt)
   );

   sat_counter #(
      .width_p     (stat_width_p),
      .inc_width_p (DROP_W)
   ) u_lost_total (
      .clk     (clk),
      .rst     (rst),
      .clr     (clear_stats),
      .inc_en  (marker_push),
      .inc_val (drop),
      .count   (lost_total)
   );

endmodule

// File: tb/tb_trace_fifo.sv
// Directed plus randomized bench for trace_fifo against a queue-based reference model.
module tb_trace_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [16:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  occupancy;
   logic [31:0] marker_cnt;
   logic [31:0] lost_total;
   logic        clear_stats;

   logic        in_ready8;
   logic [16:0] out_data8;
   logic        out_valid8;
   logic [4:0]  occupancy8;
   logic [7:0]  marker_cnt8;
   logic [7:0]  lost_total8;

   int unsigned compared   = 0;
   int unsigned mismatched = 0;

   // Reference model state
   logic [16:0] q[$];
   longint      m32, l32, m8, l8;
   localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
   localparam longint MAX8  = 64'd255;

   always #5 clk = ~clk;

   trace_fifo #(
      .sample_width_p  (16),
      .counter_width_p (16),
      .addr_width_p    (4),
      .stat_width_p    (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .occupancy   (occupancy),
      .marker_cnt  (marker_cnt),
      .lost_total  (lost_total),
      .clear_stats (clear_stats)
   );

   trace_fifo #(
      .sample_width_p  (16),
      .counter_width_p (16),
      .addr_width_p    (4),
      .stat_width_p    (8)
   ) dut8 (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready8),
      .out_data    (out_data8),
      .out_valid   (out_valid8),
      .out_ready   (out_ready),
      .occupancy   (occupancy8),
      .marker_cnt  (marker_cnt8),
      .lost_total  (lost_total8),
      .clear_stats (clear_stats)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic longint sat_add(input longint a, input longint b, input longint mx);
      return (a + b > mx) ? mx : a + b;
   endfunction

   // One clock: drive inputs, compare current DUT state with the model, then advance both.
   task automatic cyc(input logic rs, input logic v, input logic [16:0] d,
                      input logic r, input logic cs);
      logic pu, po;
      rst = rs; in_valid = v; in_data = d; out_ready = r; clear_stats = cs;
      #1;
      if (!rs) begin
         chk("occupancy", 64'(occupancy), 64'(q.size()));
         chk("in_ready", 64'(in_ready), 64'(q.size() != 16));
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         if (q.size() != 0) chk("out_data", 64'(out_data), 64'(q[0]));
         chk("marker_cnt", 64'(marker_cnt), 64'(m32));
         chk("lost_total", 64'(lost_total), 64'(l32));
         chk("marker_cnt8", 64'(marker_cnt8), 64'(m8));
         chk("lost_total8", 64'(lost_total8), 64'(l8));
      end
      if (rs) begin
         q.delete();
         m32 = 0; l32 = 0; m8 = 0; l8 = 0;
      end else begin
         pu = v && (q.size() < 16);
         po = r && (q.size() > 0);
         if (po) void'(q.pop_front());
         if (pu) q.push_back(d);
         if (cs) begin
            m32 = 0; l32 = 0; m8 = 0; l8 = 0;
         end else if (pu && d[16]) begin
            m32 = sat_add(m32, 1, MAX32);
            l32 = sat_add(l32, longint'(d[15:0]), MAX32);
            m8  = sat_add(m8, 1, MAX8);
            l8  = sat_add(l8, longint'(d[15:0]), MAX8);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [16:0] mk[5];
      logic [16:0] w;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_stats = 1'b0;
      m32 = 0; l32 = 0; m8 = 0; l8 = 0;
      repeat (2) @(posedge clk);
      #1;

      // Fill to full with out_ready low, then one rejected push attempt at full
      for (int i = 0; i < 16; i++) cyc(0, 1, 17'(i), 0, 0);
      cyc(0, 1, 17'h0_0099, 0, 0);
      // Drain in order
      for (int i = 0; i < 16; i++) cyc(0, 0, '0, 1, 0);
      cyc(0, 0, '0, 0, 0);

      // Markers interleaved with samples
      mk[0] = 17'h0_0010; mk[1] = 17'h1_0003; mk[2] = 17'h0_0011;
      mk[3] = 17'h1_0005; mk[4] = 17'h0_0012;
      for (int i = 0; i < 5; i++) cyc(0, 1, mk[i], 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 0, '0, 1, 0);

      // Simultaneous push/pop at occupancy 3 across pointer wrap
      for (int i = 0; i < 3; i++) cyc(0, 1, 17'(16'h0100 + i), 0, 0);
      for (int i = 0; i < 20; i++) cyc(0, 1, 17'(16'h0200 + i), 1, 0);

      // Top up to full, then push+pop at full: pop only, push next cycle
      for (int i = 0; i < 13; i++) cyc(0, 1, 17'(16'h0300 + i), 0, 0);
      cyc(0, 1, 17'h0_0AAA, 1, 0);
      cyc(0, 1, 17'h0_0BBB, 0, 0);
      for (int i = 0; i < 17; i++) cyc(0, 0, '0, 1, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         w = 17'($urandom);
         w[16] = ($urandom_range(0, 3) == 0);
         cyc(0, 1'($urandom), w, 1'($urandom), ($urandom_range(0, 60) == 0));
      end

      // Saturation of the 8-bit statistics, then clear coincident with a marker push
      for (int i = 0; i < 262; i++) cyc(0, 1, 17'h1_FFFF, 1, 0);
      cyc(0, 1, 17'h1_0007, 1, 1);
      cyc(0, 0, '0, 1, 0);
      cyc(0, 0, '0, 1, 0);

      // Reset mid-stream at occupancy 7, first post-reset push
      for (int i = 0; i < 7; i++) cyc(0, 1, 17'(16'h0400 + i), 0, 0);
      cyc(0, 0, '0, 0, 0);
      cyc(1, 1, 17'h1_0009, 1, 0);
      cyc(0, 1, 17'h0_0ABC, 0, 0);
      cyc(0, 0, '0, 0, 0);
      cyc(0, 0, '0, 1, 0);
      cyc(0, 0, '0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/trace_fifo.md
Name: trace_fifo

Overview:
- Buffering stage directly downstream of the trace backpressure stage.
- Accepts tagged trace words over valid/ready. Bit [sample_width_p] set = overflow marker whose low counter_width_p bits carry a dropped-sample count; clear = raw sample.
- Stores the words in a show-ahead circular buffer and drains them to the trace link over valid/ready.
- Maintains saturating statistics: total markers and total samples reported lost.

Parameters:
- sample_width_p, 16, width of a raw sample; stored word width is sample_width_p+1.
- counter_width_p, 16, width of the drop-count field in marker words; must be <= sample_width_p.
- addr_width_p, 4, buffer depth = 2**addr_width_p entries.
- stat_width_p, 32, width of the statistics counters.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  sample_width_p+1  tagged trace word from the backpressure stage.
- in_valid  input  1  in_data valid.
- in_ready  output  1  buffer can accept a word this cycle.
- out_data  output  sample_width_p+1  word at buffer head.
- out_valid  output  1  buffer non-empty.
- out_ready  input  1  link consumes the head word.
- occupancy  output  addr_width_p+1  current entry count, 0..2**addr_width_p.
- marker_cnt  output  stat_width_p  accepted marker words, saturating.
- lost_total  output  stat_width_p  sum of drop counts from accepted markers, saturating.
- clear_stats  input  1  synchronous clear of marker_cnt and lost_total.

Behaviour:
- Push = in_valid && in_ready. Pop = out_valid && out_ready. Both may occur in the same cycle.
- in_ready = (occupancy != 2**addr_width_p). It depends only on registered state, never on out_ready. When full, a simultaneous pop does not allow a push that cycle.
- out_valid = (occupancy != 0).
- out_data = mem[rd_ptr], a combinational read of the register array. Value is don't-care when out_valid=0.
- Latency: a word pushed in cycle N appears on out_data/out_valid in cycle N+1 when the buffer was empty. No same-cycle bypass.
- Pointers: wr_ptr and rd_ptr are addr_width_p bits and wrap modulo depth. Full/empty are derived from occupancy, not from pointer equality.
- occupancy next value:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push+pop or on neither.
- Ordering is strict FIFO. Markers and samples are never reordered or dropped inside this block.
- Statistics, updated on push of a word with in_data[sample_width_p]==1:
  - marker_cnt += 1.
  - lost_total += zero-extended in_data[counter_width_p-1:0].
  - Both saturate at all-ones and never wrap.
  - Samples (MSB=0) do not affect the statistics.
- clear_stats has priority over a simultaneous marker push: the counters go to 0 and that marker is not counted.
- Reset, including mid-stream:
  - wr_ptr, rd_ptr and occupancy go to 0; out_valid=0.
  - in_ready=1 from the first cycle after reset.
  - marker_cnt=0, lost_total=0.
  - Memory contents are not reset. Any in-flight push/pop in the reset cycle is ignored.
- Holding out_ready=0 keeps out_data stable while out_valid=1.

Decomposition:
- Shared package trace_pkg holds:
  - localparam for the marker flag bit position.
  - typedef trace_word_t (flag bit + payload).
  - A function returning the drop count from a marker word.
- One natural sub-module: sat_counter (stat_width_p wide; inputs inc_en, inc_val, clr). Instantiate it twice, for marker_cnt and lost_total.
- Storage and pointer logic stay in trace_fifo.

Test Plan:
- Fill/drain: push 16 samples 0x0000..0x000F with out_ready=0 -> in_ready=0 after the 16th push, occupancy=16. Then set out_ready=1 -> outputs appear in order 0x0000..0x000F and occupancy returns to 0.
- Marker accounting: push markers 0x1_0003 and 0x1_0005 interleaved with samples -> marker_cnt=2, lost_total=8, and the markers emerge at their pushed positions.
- Simultaneous push/pop at occupancy=3 over 20 cycles -> occupancy stays 3, data order preserved across pointer wrap.
- Full with pop: occupancy=16, in_valid=1, out_ready=1 -> in_ready=0 that cycle; occupancy=15 next cycle, then the push is accepted.
- Saturation: with stat_width_p=8, push markers of count 0xFFFF until lost_total=0xFF -> it stays 0xFF. A clear_stats pulse coincident with a marker push -> both counters 0.
- Reset mid-stream with occupancy=7 -> next cycle out_valid=0, occupancy=0, in_ready=1. The first post-reset push appears at the output one cycle later.
